// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
// Bundles the requester-side handshake and the shared ROM port of the
// rom_arbiter into one interface.
//   req          requester read requests, level, held until ack
//   addr         packed requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   ack          one-hot, one-cycle pulse marking rd_data valid for a requester
//   rd_data      read data returned to the acknowledged requester
//   busy         high while a ROM read is in flight
//   rom_address  registered address driven to the shared ROM
//   rom_q        data coming back from the shared ROM
// The slave modport is the arbiter's view; master is the environment's view.
interface rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rd_data;
    logic                    busy;
    logic [ADDR_W-1:0]       rom_address;
    logic [DATA_W-1:0]       rom_q;

    modport slave (
        input  req,
        input  addr,
        input  rom_q,
        output ack,
        output rd_data,
        output busy,
        output rom_address
    );

    modport master (
        output req,
        output addr,
        output rom_q,
        input  ack,
        input  rd_data,
        input  busy,
        input  rom_address
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter
// Round-robin arbiter that lets N_REQ requesters share a single ROM with a
// fixed read latency of ROM_LAT cycles. Only one ROM read is outstanding at a
// time; each read walks IDLE -> WAIT -> RESP and returns to IDLE.
//   clk    single rising-edge clock
//   reset  synchronous, active-high reset
//   bus    rom_arbiter_if.slave: req/addr in, ack/rd_data/busy out,
//          rom_address out to the ROM, rom_q back from the ROM
module rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    rom_arbiter_if.slave   bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    pick;
    logic [1:0]          lat_cnt;
    logic [DATA_W-1:0]   rd_data_r;
    logic [ADDR_W-1:0]   rom_address_r;
    logic [N_REQ-1:0]    ack_c;
    logic                busy_c;

    // First requester with req set, searching cyclically from the pointer.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] sel;
        logic             hit;
        int               idx;
        sel = p;
        hit = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                sel = PTR_W'(idx);
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.req, rr_ptr);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the decoded outputs. The ack pulse is masked by reset so
    // that a reset landing in the RESP cycle aborts without any visible ack.
    always_comb begin
        state_next = state;
        ack_c      = '0;
        busy_c     = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy_c = 1'b1;
                if (lat_cnt == 2'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                busy_c     = 1'b1;
                state_next = IDLE;
                if (!reset) begin
                    ack_c[owner] = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The WAIT count starts at ROM_LAT on the cycle rom_address is
    // first presented and the capture happens once it has run down to zero,
    // which is exactly the cycle the ROM's data for that address arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner         <= '0;
            rr_ptr        <= '0;
            lat_cnt       <= '0;
            rd_data_r     <= '0;
            rom_address_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner         <= pick;
                        rom_address_r <= bus.addr[int'(pick)*ADDR_W +: ADDR_W];
                        lat_cnt       <= 2'(ROM_LAT);
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rd_data_r <= bus.rom_q;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack         = ack_c;
    assign bus.busy        = busy_c;
    assign bus.rd_data     = rd_data_r;
    assign bus.rom_address = rom_address_r;

endmodule
